lcd_sprite_streamer: RTL and testbench

//  Parametrised successor to the fixed-content picture ROMs of the graphic LCD path. It streams a sprite
//  to the LCD command/data stream with a runtime column (X) and page position, and a frame index for animation.

---
 rtl/lcd_sprite_streamer.sv | 177 +++++++++++++++++
 tb/tb_lcd_sprite_streamer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_sprite_streamer.sv
// lcd_sprite_streamer
// Streams one sprite frame from an external synchronous ROM to the LCD
// command/data stream as {byte, rs} words: a page-select command, a column-
// select command, then the visible column bytes, repeated for each page that
// fits on the 64x64 panel. Supports draw (ROM bytes) and erase (0x00) modes.
module lcd_sprite_streamer #(
    parameter int SPR_W     = 24,
    parameter int SPR_PAGES = 3,
    parameter int FRAMES    = 2,
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [5:0]        x_i,
    input  logic [2:0]        page_i,
    input  logic [7:0]        frame_i,
    input  logic              erase_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic [8:0]        cmd_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAGE,
        S_COL,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0]        LP_FMAX = 8'(FRAMES - 1);
    localparam logic [ADDR_W-1:0] LP_FSZ  = ADDR_W'(SPR_PAGES * SPR_W);
    localparam logic [ADDR_W-1:0] LP_PSZ  = ADDR_W'(SPR_W);
    localparam logic [6:0]        LP_W    = 7'(SPR_W);
    localparam logic [3:0]        LP_NP   = 4'(SPR_PAGES);

    state_t r_state;
    state_t w_next;

    // Transfer context latched at start
    logic [5:0]        r_x;
    logic [3:0]        r_pg;      // absolute LCD page of the current sprite page
    logic [3:0]        r_p;       // sprite-relative page index
    logic              r_erase;
    logic [6:0]        r_vis;     // visible columns after right-edge clipping
    logic [6:0]        r_c;       // current column within the page
    logic [ADDR_W-1:0] r_base;    // ROM offset of the selected frame
    logic [ADDR_W-1:0] r_poff;    // ROM offset of the current page within the frame
    logic [CNT_W-1:0]  r_cnt;

    logic [7:0]        w_frame;
    logic [ADDR_W-1:0] w_base;
    logic [6:0]        w_room;
    logic [6:0]        w_vis;
    logic              w_xfer;
    logic              w_start;
    logic              w_last_col;
    logic              w_more;
    logic              w_adv;
    logic [ADDR_W-1:0] w_addr;

    // Out-of-range frame indices select the last stored frame
    assign w_frame    = (frame_i > LP_FMAX) ? LP_FMAX : frame_i;
    assign w_base     = ADDR_W'(w_frame) * LP_FSZ;
    assign w_room     = 7'd64 - {1'b0, x_i};
    assign w_vis      = (LP_W < w_room) ? LP_W : w_room;

    assign w_xfer     = cmd_valid_o & cmd_ready_i;
    assign w_start    = (r_state == S_IDLE) & start_i & ~abort_i;
    assign w_last_col = (r_c == r_vis - 7'd1);
    // Stop after the sprite's last page or the panel's last page, whichever first
    assign w_more     = ((r_p + 4'd1) < LP_NP) && (r_pg < 4'd7);

    // The ROM address runs one column ahead when a data word is accepted, so the
    // next byte arrives just in time for back-to-back transfers. While stalled the
    // address holds, which keeps rom_data_i (and so cmd_o) stable.
    assign w_addr     = r_base + r_poff + ADDR_W'(r_c);
    assign w_adv      = (r_state == S_DATA) & w_xfer;
    assign rom_addr_o = w_addr + ADDR_W'(w_adv);
    assign cnt_o      = r_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_next = r_state;
        if (abort_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) w_next = S_PAGE;
                S_PAGE: if (w_xfer) w_next = S_COL;
                S_COL:  if (w_xfer) w_next = S_DATA;
                S_DATA: if (w_xfer && w_last_col) w_next = w_more ? S_PAGE : S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        cmd_o       = 9'd0;
        cmd_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_PAGE: begin
                cmd_o       = {8'hB8 | {5'd0, r_pg[2:0]}, 1'b0};
                cmd_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_COL: begin
                cmd_o       = {8'h40 | {2'd0, r_x}, 1'b0};
                cmd_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_DATA: begin
                cmd_o       = {r_erase ? 8'h00 : rom_data_i, 1'b1};
                cmd_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    // Transfer context, column/page walk and accepted-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_pg    <= '0;
            r_p     <= '0;
            r_erase <= 1'b0;
            r_vis   <= '0;
            r_c     <= '0;
            r_base  <= '0;
            r_poff  <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_x     <= x_i;
            r_pg    <= {1'b0, page_i};
            r_p     <= '0;
            r_erase <= erase_i;
            r_vis   <= w_vis;
            r_c     <= '0;
            r_base  <= w_base;
            r_poff  <= '0;
            r_cnt   <= '0;
        end else if (!abort_i) begin
            if (w_xfer) r_cnt <= r_cnt + CNT_W'(1);
            if (w_adv) begin
                if (w_last_col) begin
                    r_c    <= '0;
                    r_p    <= r_p + 4'd1;
                    r_pg   <= r_pg + 4'd1;
                    r_poff <= r_poff + LP_PSZ;
                end else begin
                    r_c    <= r_c + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_sprite_streamer.sv
// Randomized bench for lcd_sprite_streamer: each transfer is compared word by
// word with an expected stream built from the sprite layout rules.
module tb_lcd_sprite_streamer;

    localparam int SPR_W     = 24;
    localparam int SPR_PAGES = 3;
    localparam int FRAMES    = 2;
    localparam int ADDR_W    = 10;
    localparam int CNT_W     = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [5:0]        x_i = '0;
    logic [2:0]        page_i = '0;
    logic [7:0]        frame_i = '0;
    logic              erase_i = 1'b0;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [7:0]        rom_data_i;
    logic [8:0]        cmd_o;
    logic              cmd_valid_o;
    logic              cmd_ready_i = 1'b0;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  cnt_o;

    logic [7:0] rom [0:1023];
    int n_chk = 0;
    int n_fail = 0;

    lcd_sprite_streamer #(
        .SPR_W(SPR_W), .SPR_PAGES(SPR_PAGES), .FRAMES(FRAMES),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .x_i(x_i), .page_i(page_i), .frame_i(frame_i), .erase_i(erase_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // synchronous sprite ROM
    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive a start at the current negedge, then follow the whole transfer.
    task automatic run_xfer(input int x, input int pg, input int fr, input int er,
                            input bit rnd, input bit poke);
        logic [8:0] q[$];
        int f, vis, idx, cyc, vcyc;
        bit stalled, xfer;
        logic [8:0] prev;
        f   = (fr >= FRAMES) ? FRAMES - 1 : fr;
        vis = (SPR_W < 64 - x) ? SPR_W : 64 - x;
        for (int p = 0; p < SPR_PAGES; p++) begin
            if (pg + p <= 7) begin
                q.push_back({8'(8'hB8 + pg + p), 1'b0});
                q.push_back({8'(8'h40 + x), 1'b0});
                for (int c = 0; c < vis; c++)
                    q.push_back({(er != 0) ? 8'h00 : rom[f*SPR_PAGES*SPR_W + p*SPR_W + c], 1'b1});
            end
        end
        x_i = 6'(x); page_i = 3'(pg); frame_i = 8'(fr); erase_i = (er != 0);
        start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        chk("lat_valid", cmd_valid_o, 1);
        chk("lat_busy", busy_o, 1);
        chk("cnt_clear", cnt_o, 0);
        idx = 0; cyc = 0; vcyc = 0; stalled = 0; prev = '0;
        while (cyc < 3000 && !done_o) begin
            chk("valid", cmd_valid_o, 1);
            chk("busy", busy_o, 1);
            if (cmd_valid_o) begin
                vcyc++;
                if (stalled) chk("stable", cmd_o, prev);
                chk($sformatf("word%0d", idx), cmd_o, (idx < q.size()) ? q[idx] : 9'h1FF);
                if (idx == 1) chk("col_addr", rom_addr_o, f*SPR_PAGES*SPR_W);
            end
            if (poke && idx == 5) begin
                start_i = 1'b1;
                x_i = 6'($urandom);
                page_i = 3'($urandom);
            end else begin
                start_i = 1'b0;
            end
            cmd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer    = cmd_valid_o && cmd_ready_i;
            stalled = cmd_valid_o && !cmd_ready_i;
            prev    = cmd_o;
            @(posedge clk);
            if (xfer) idx++;
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        chk("done_seen", done_o, 1);
        chk("nwords", idx, q.size());
        chk("cnt_end", cnt_o, q.size());
        chk("busy_at_done", busy_o, 0);
        chk("valid_at_done", cmd_valid_o, 0);
        if (!rnd) chk("one_per_clk", vcyc, q.size());
        @(negedge clk);
        chk("done_pulse", done_o, 0);
        chk("cnt_hold", cnt_o, q.size());
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_cmd", cmd_o, 0);
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_addr", rom_addr_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(10, 1, 0, 0, 0, 0);   // 78 words
        run_xfer(50, 0, 0, 0, 0, 0);   // vis 14, 48 words
        run_xfer(10, 6, 5, 0, 0, 1);   // pages 6,7, frame clamp, start while busy
        run_xfer(10, 1, 0, 1, 1, 0);   // erase with stalls
        run_xfer(63, 7, 1, 0, 0, 0);   // 1 column, 1 page
        repeat (6)
            run_xfer($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 1), 1, 1'($urandom_range(0, 1)));

        // abort in DATA, restart next cycle
        x_i = 6'd10; page_i = 3'd1; frame_i = 8'd0; erase_i = 1'b0;
        start_i = 1'b1; cmd_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        repeat (12) @(negedge clk);
        cmd_ready_i = 1'b0; abort_i = 1'b1;
        @(posedge clk); @(negedge clk);
        abort_i = 1'b0;
        chk("abort_valid", cmd_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_cnt", cnt_o, 12);
        run_xfer(10, 1, 0, 0, 0, 0);

        // abort and start together: nothing starts
        start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        chk("abst_busy", busy_o, 0);
        chk("abst_valid", cmd_valid_o, 0);
        @(negedge clk);
        chk("abst_busy2", busy_o, 0);

        // asynchronous reset mid-transfer
        x_i = 6'd10; page_i = 3'd1; frame_i = 8'd1;
        start_i = 1'b1; cmd_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_cmd", cmd_o, 0);
        chk("mrst_valid", cmd_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_cnt", cnt_o, 0);
        chk("mrst_addr", rom_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(20, 2, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
